// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state codes, opcode class
// headers and a small opcode-class helper.
package control_sequencer_pkg;

    // Control state codes consumed by control_decode; 12-14 are unused.
    typedef enum logic [3:0] {
        ST_IF      = 4'd0,
        ST_RF      = 4'd1,
        ST_IMM3    = 4'd2,
        ST_ALU_R3  = 4'd3,
        ST_ALU_RI3 = 4'd4,
        ST_ALU4    = 4'd5,
        ST_BRANCH3 = 4'd6,
        ST_MEMREF3 = 4'd7,
        ST_LOAD4   = 4'd8,
        ST_STORE4  = 4'd9,
        ST_LOAD5   = 4'd10,
        ST_JUMP3   = 4'd11,
        ST_HALT    = 4'd15
    } state_e;

    // Opcode class headers, taken from opcode[5:3].
    localparam logic [2:0] ALU_R_HEADER      = 3'b000;
    localparam logic [2:0] ALU_RI_HEADER     = 3'b001;
    localparam logic [2:0] BRANCH_HEADER     = 3'b010;
    localparam logic [2:0] MEMORY_REF_HEADER = 3'b011;
    localparam logic [2:0] JUMP_HEADER       = 3'b100;
    localparam logic [2:0] IMM_HEADER        = 3'b101;

    // Classes 110 and 111 have no defined instruction and force HALT.
    function automatic logic is_illegal_class(input logic [2:0] cls);
        return (cls[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle of the sequencer's IR/memory inputs and control outputs.
// master = instruction/memory side, slave = the sequencer itself.
interface control_sequencer_if #(
    parameter int COUNT_W = 32
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic [3:0]         state;
    logic               retire;
    logic               halted;
    logic               illegal_op;
    logic [COUNT_W-1:0] retire_count;

    modport master (
        output opcode, mem_ready,
        input  state, retire, halted, illegal_op, retire_count
    );

    modport slave (
        input  opcode, mem_ready,
        output state, retire, halted, illegal_op, retire_count
    );
endinterface

// File: rtl/control_retire_counter.sv
// Saturating retired-instruction counter; holds at all-ones instead of wrapping.
module control_retire_counter #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    // Next count: step on inc unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control state machine: walks fetch/decode/execute states per
// opcode class, stalls on mem_ready, reports retirement and halts on an
// illegal opcode class until reset.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    control_sequencer_if.slave  bus
);
    state_e state_q;
    state_e state_d;
    logic   illegal_q;
    logic   illegal_d;
    logic   retire_c;
    logic [COUNT_W-1:0] count_w;

    // Next-state decode and combinational retire strobe.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        retire_c  = 1'b0;
        case (state_q)
            ST_IF: begin
                if (bus.mem_ready) state_d = ST_RF;
            end
            ST_RF: begin
                case (bus.opcode[5:3])
                    ALU_R_HEADER:      state_d = ST_ALU_R3;
                    ALU_RI_HEADER:     state_d = ST_ALU_RI3;
                    BRANCH_HEADER:     state_d = ST_BRANCH3;
                    MEMORY_REF_HEADER: state_d = ST_MEMREF3;
                    JUMP_HEADER:       state_d = ST_JUMP3;
                    IMM_HEADER:        state_d = ST_IMM3;
                    default: begin
                        state_d   = ST_HALT;
                        illegal_d = is_illegal_class(bus.opcode[5:3]);
                    end
                endcase
            end
            ST_ALU_R3, ST_ALU_RI3: begin
                state_d = ST_ALU4;
            end
            ST_ALU4, ST_BRANCH3, ST_JUMP3, ST_IMM3, ST_LOAD5: begin
                state_d  = ST_IF;
                retire_c = 1'b1;
            end
            ST_MEMREF3: begin
                state_d = bus.opcode[2] ? ST_STORE4 : ST_LOAD4;
            end
            ST_LOAD4: begin
                if (bus.mem_ready) state_d = ST_LOAD5;
            end
            ST_STORE4: begin
                if (bus.mem_ready) begin
                    state_d  = ST_IF;
                    retire_c = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                // Unused codes recover to fetch without retiring anything.
                state_d = ST_IF;
            end
        endcase
    end

    // State and illegal-op pulse registers, asynchronously reset to fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IF;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    control_retire_counter #(
        .COUNT_W (COUNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire_c),
        .count (count_w)
    );

    assign bus.state        = state_q;
    assign bus.retire       = retire_c;
    assign bus.halted       = (state_q == ST_HALT);
    assign bus.illegal_op   = illegal_q;
    assign bus.retire_count = count_w;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver expands each instruction
// into its expected per-cycle state/retire trace, a negedge monitor compares.
module tb_control_sequencer;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    control_sequencer_if #(.COUNT_W(CW)) bus ();

    control_sequencer #(.COUNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int st;
        bit ret;
        bit halt;
        bit ill;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   exp_cnt  = 0;
    bit   checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic bit rnd1();
        return 1'($urandom);
    endfunction

    // Monitor: every cycle the DUT presents a state, compare against the queue.
    always @(negedge clk) begin
        if (checking && (q.size() > 0)) begin
            mon_e = q.pop_front();
            chk("state",        int'(bus.state),        mon_e.st);
            chk("retire",       int'(bus.retire),       int'(mon_e.ret));
            chk("halted",       int'(bus.halted),       int'(mon_e.halt));
            chk("illegal_op",   int'(bus.illegal_op),   int'(mon_e.ill));
            chk("retire_count", int'(bus.retire_count), mon_e.cnt);
        end
    end

    // One cycle: apply inputs, record what the DUT should show, advance.
    task automatic cyc(input int st, input bit ret, input bit ill,
                       input logic [5:0] op, input bit mr);
        exp_t e;
        bus.opcode    = op;
        bus.mem_ready = mr;
        e.st   = st;
        e.ret  = ret;
        e.halt = (st == 15);
        e.ill  = ill;
        e.cnt  = exp_cnt;
        q.push_back(e);
        if (ret && exp_cnt < MAXC) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Reference trace of one instruction from its class and stall counts.
    task automatic run_instr(input logic [5:0] op, input int if_st,
                             input int mem_st, input int halt_cycles);
        repeat (if_st) cyc(0, 0, 0, rnd6(), 0);
        cyc(0, 0, 0, rnd6(), 1);
        cyc(1, 0, 0, op, rnd1());
        case (op[5:3])
            3'd0: begin cyc(3, 0, 0, rnd6(), rnd1()); cyc(5, 1, 0, rnd6(), rnd1()); end
            3'd1: begin cyc(4, 0, 0, rnd6(), rnd1()); cyc(5, 1, 0, rnd6(), rnd1()); end
            3'd2: cyc(6, 1, 0, rnd6(), rnd1());
            3'd4: cyc(11, 1, 0, rnd6(), rnd1());
            3'd5: cyc(2, 1, 0, rnd6(), rnd1());
            3'd3: begin
                cyc(7, 0, 0, op, rnd1());
                if (op[2]) begin
                    repeat (mem_st) cyc(9, 0, 0, rnd6(), 0);
                    cyc(9, 1, 0, rnd6(), 1);
                end else begin
                    repeat (mem_st) cyc(8, 0, 0, rnd6(), 0);
                    cyc(8, 0, 0, rnd6(), 1);
                    cyc(10, 1, 0, rnd6(), rnd1());
                end
            end
            default: begin
                cyc(15, 0, 1, rnd6(), rnd1());
                repeat (halt_cycles) cyc(15, 0, 0, rnd6(), rnd1());
            end
        endcase
    endtask

    // Asynchronous reset mid-cycle, checked before the next clock edge.
    task automatic do_reset(input int st_before);
        #3;
        chk("pre_reset_state", int'(bus.state), st_before);
        checking = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_state",      int'(bus.state),        0);
        chk("rst_count",      int'(bus.retire_count), 0);
        chk("rst_halted",     int'(bus.halted),       0);
        chk("rst_retire",     int'(bus.retire),       0);
        chk("rst_illegal_op", int'(bus.illegal_op),   0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        exp_cnt  = 0;
        checking = 1'b1;
    endtask

    initial begin
        logic [5:0] op;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("init_state",      int'(bus.state),        0);
        chk("init_count",      int'(bus.retire_count), 0);
        chk("init_halted",     int'(bus.halted),       0);
        chk("init_illegal_op", int'(bus.illegal_op),   0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        checking = 1'b1;

        // ALU R: 0,1,3,5
        run_instr(6'b000010, 0, 0, 0);
        chk("alu_count", int'(bus.retire_count), 1);
        // Load with two LOAD4 stalls: 0,1,7,8,8,8,10
        run_instr(6'b011000, 0, 2, 0);
        chk("load_count", int'(bus.retire_count), 2);
        // Store then jump back to back
        run_instr(6'b011100, 0, 0, 0);
        run_instr(6'b100000, 0, 0, 0);
        chk("store_jump_count", int'(bus.retire_count), 4);
        // IF stall followed by ALU RI and branch
        run_instr(6'b001011, 2, 0, 0);
        run_instr(6'b010101, 1, 0, 0);

        // Reset while stalled in LOAD4
        cyc(0, 0, 0, rnd6(), 1);
        cyc(1, 0, 0, 6'b011000, 1);
        cyc(7, 0, 0, 6'b011000, 1);
        cyc(8, 0, 0, rnd6(), 0);
        cyc(8, 0, 0, rnd6(), 0);
        bus.mem_ready = 1'b0;
        do_reset(8);

        // Illegal opcode: sticky HALT until reset
        run_instr(6'b110000, 0, 0, 5);
        do_reset(15);

        // Saturation: 17 immediate injections with a 4-bit counter
        repeat (17) run_instr(6'b101000, 0, 0, 0);
        chk("sat_count", int'(bus.retire_count), MAXC);
        run_instr(6'b101000, 0, 0, 0);
        chk("sat_hold", int'(bus.retire_count), MAXC);
        do_reset(0);

        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                op = {2'b11, 1'($urandom), 3'($urandom)};
                run_instr(op, $urandom_range(0, 2), 0, $urandom_range(0, 3));
                do_reset(15);
            end else begin
                op = {3'($urandom_range(0, 5)), 3'($urandom)};
                run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 0);
            end
        end

        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
